// File: rtl/rpn_display_driver_if.sv
// Bundles the calculator-side inputs and the display-side outputs of the
// eight-digit multiplexed seven-segment driver.
interface rpn_display_driver_if;
    logic [15:0] ToDisplay;  // value shown as four hex digits
    logic [3:0]  Flags;      // {N,Z,C,V}
    logic [2:0]  Status;     // sequencer state, one hex digit
    logic [7:0]  Anodes;     // active-low digit enables, bit 0 = rightmost
    logic [6:0]  Segments;   // active-low {CA,CB,CC,CD,CE,CF,CG}
    logic [3:0]  FlagsLED;   // active-high {N,Z,C,V}

    // Calculator / testbench side
    modport master (
        output ToDisplay, Flags, Status,
        input  Anodes, Segments, FlagsLED
    );

    // Display driver side
    modport slave (
        input  ToDisplay, Flags, Status,
        output Anodes, Segments, FlagsLED
    );
endinterface

// File: rtl/rpn_display_driver.sv
// Time-multiplexed driver for an eight-digit seven-segment display.
// Digits 0..3 show the calculator value in hex, digit 6 shows the sequencer
// state, digits 4, 5 and 7 are blank. Inputs are sampled into shadow
// registers once per frame so a digit never changes in the middle of a scan.
module rpn_display_driver #(
    parameter int COUNT_MAX = 50000,  // cycles each digit stays active (2..65535)
    parameter bit LZB       = 1'b1    // leading-zero blanking of the hex field
) (
    input  logic                 clk,
    input  logic                 resetN,
    rpn_display_driver_if.slave  bus
);

    localparam logic [15:0] TC_VALUE = 16'(COUNT_MAX - 1);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    logic [15:0] r_prescale;
    logic [2:0]  r_idx;
    logic        r_load_pending;
    logic [15:0] r_sh_display;
    logic [3:0]  r_sh_flags;
    logic [2:0]  r_sh_status;
    logic [7:0]  r_anodes;
    logic [6:0]  r_segments;
    logic [3:0]  r_flags_led;

    logic        w_tc;
    logic        w_load;
    logic [3:1]  w_lz_blank;
    logic [6:0]  w_seg_next;

    // Active-low hex font for one nibble.
    function automatic logic [6:0] f_hex7(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'b0000001;
            4'h1:    return 7'b1001111;
            4'h2:    return 7'b0010010;
            4'h3:    return 7'b0000110;
            4'h4:    return 7'b1001100;
            4'h5:    return 7'b0100100;
            4'h6:    return 7'b0100000;
            4'h7:    return 7'b0001111;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0000100;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b1100000;
            4'hC:    return 7'b0110001;
            4'hD:    return 7'b1000010;
            4'hE:    return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    assign w_tc   = (r_prescale == TC_VALUE);
    // Shadows refresh on the frame wrap, or once right after reset release.
    assign w_load = r_load_pending || (w_tc && (r_idx == 3'd7));

    // Digit k is a leading zero when it and every higher nibble are zero.
    assign w_lz_blank[3] = LZB && (r_sh_display[15:12] == 4'h0);
    assign w_lz_blank[2] = LZB && (r_sh_display[15:8]  == 8'h00);
    assign w_lz_blank[1] = LZB && (r_sh_display[15:4]  == 12'h000);

    // Prescaler and digit index: one index step per COUNT_MAX cycles.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching the hardware.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_prescale <= '0;
            r_idx      <= '0;
        end else if (w_tc) begin
            r_prescale <= '0;
            r_idx      <= r_idx + 3'd1;
        end else begin
            r_prescale <= r_prescale + 16'd1;
        end
    end

    // Shadow registers: the display never looks at the live inputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_load_pending <= 1'b1;
            r_sh_display   <= '0;
            r_sh_flags     <= '0;
            r_sh_status    <= '0;
        end else begin
            r_load_pending <= 1'b0;
            if (w_load) begin
                r_sh_display <= bus.ToDisplay;
                r_sh_flags   <= bus.Flags;
                r_sh_status  <= bus.Status;
            end
        end
    end

    // Segment pattern for the digit currently selected by the index.
    // NOTE: the default is assigned first so no path leaves w_seg_next
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_seg_next = SEG_BLANK;
        case (r_idx)
            3'd0: w_seg_next = f_hex7(r_sh_display[3:0]);
            3'd1: w_seg_next = w_lz_blank[1] ? SEG_BLANK : f_hex7(r_sh_display[7:4]);
            3'd2: w_seg_next = w_lz_blank[2] ? SEG_BLANK : f_hex7(r_sh_display[11:8]);
            3'd3: w_seg_next = w_lz_blank[3] ? SEG_BLANK : f_hex7(r_sh_display[15:12]);
            3'd6: w_seg_next = f_hex7({1'b0, r_sh_status});
            default: w_seg_next = SEG_BLANK;
        endcase
    end

    // Registered outputs, one cycle behind index and shadows (glitch-free pins).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_anodes    <= 8'hFF;
            r_segments  <= SEG_BLANK;
            r_flags_led <= 4'h0;
        end else begin
            r_anodes    <= ~(8'b1 << r_idx);
            r_segments  <= w_seg_next;
            r_flags_led <= r_sh_flags;
        end
    end

    assign bus.Anodes   = r_anodes;
    assign bus.Segments = r_segments;
    assign bus.FlagsLED = r_flags_led;

endmodule

// File: tb/tb_rpn_display_driver.sv
// Self-checking bench for rpn_display_driver with COUNT_MAX=4. Two instances
// (LZB=1 and LZB=0) share the inputs; a frame-level model predicts every
// output cycle, and directed checks pin the model with literal expectations.
module tb_rpn_display_driver;

    localparam int CM = 4;

    logic clk;
    logic resetN;

    rpn_display_driver_if bus1 ();
    rpn_display_driver_if bus0 ();

    rpn_display_driver #(.COUNT_MAX(CM), .LZB(1'b1)) dut_lzb1 (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus1)
    );

    rpn_display_driver #(.COUNT_MAX(CM), .LZB(1'b0)) dut_lzb0 (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Font table written out from the hex encoding list.
    logic [6:0] font [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // What digit `idx` must look like for a given snapshot of the inputs.
    function automatic logic [6:0] model_seg(input int idx, input int value,
                                             input int status, input bit lzb);
        int nib;
        if (idx < 4) begin
            nib = (value >> (4 * idx)) & 15;
            if (lzb && idx > 0 && (value >> (4 * idx)) == 0) return 7'h7F;
            return font[nib];
        end
        if (idx == 6) return font[status];
        return 7'h7F;
    endfunction

    // Model: edges since release give the digit; snapshots taken on the
    // first edge and on the last edge of every 8*CM-cycle frame.
    int         m_cnt    = 0;
    int         m_disp   = 0;
    int         m_status = 0;
    logic [3:0] m_flags  = '0;
    logic [7:0] exp_an   = 8'hFF;
    logic [6:0] exp_seg1 = 7'h7F;
    logic [6:0] exp_seg0 = 7'h7F;
    logic [3:0] exp_led  = 4'h0;
    bit         en_cmp   = 1'b0;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_cnt    <= 0;
            m_disp   <= 0;
            m_status <= 0;
            m_flags  <= '0;
            exp_an   <= 8'hFF;
            exp_seg1 <= 7'h7F;
            exp_seg0 <= 7'h7F;
            exp_led  <= 4'h0;
        end else begin
            exp_an   <= ~(8'b1 << ((m_cnt / CM) % 8));
            exp_seg1 <= model_seg((m_cnt / CM) % 8, m_disp, m_status, 1'b1);
            exp_seg0 <= model_seg((m_cnt / CM) % 8, m_disp, m_status, 1'b0);
            exp_led  <= m_flags;
            if (m_cnt == 0 || (m_cnt + 1) % (8 * CM) == 0) begin
                m_disp   <= int'(bus1.ToDisplay);
                m_status <= int'(bus1.Status);
                m_flags  <= bus1.Flags;
            end
            m_cnt <= m_cnt + 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (en_cmp) begin
            check("model_anodes_lzb1", 32'(bus1.Anodes),   32'(exp_an));
            check("model_seg_lzb1",    32'(bus1.Segments), 32'(exp_seg1));
            check("model_led_lzb1",    32'(bus1.FlagsLED), 32'(exp_led));
            check("model_anodes_lzb0", 32'(bus0.Anodes),   32'(exp_an));
            check("model_seg_lzb0",    32'(bus0.Segments), 32'(exp_seg0));
            check("model_led_lzb0",    32'(bus0.FlagsLED), 32'(exp_led));
        end
    end

    task automatic set_inputs(input logic [15:0] d, input logic [3:0] f, input logic [2:0] s);
        bus1.ToDisplay = d; bus1.Flags = f; bus1.Status = s;
        bus0.ToDisplay = d; bus0.Flags = f; bus0.Status = s;
    endtask

    // Wait (bounded) until digit k is active, returning on a negedge.
    task automatic wait_anode(input int k);
        logic [7:0] target;
        bit         found;
        target = ~(8'b1 << k);
        found  = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (bus1.Anodes == target) found = 1'b1;
        end
        if (!found) check("timeout_wait_anode", 32'(k), 32'hFFFF_FFFF);
    endtask

    // Align to the first cycle of the next AN0 after an AN7.
    task automatic next_frame();
        wait_anode(7);
        wait_anode(0);
    endtask

    initial begin
        resetN = 1'b0;
        set_inputs(16'h0100, 4'b0010, 3'd3);
        #12;
        en_cmp = 1'b1;

        // Reset values, then first edge after release.
        check("reset_anodes", 32'(bus1.Anodes),   32'hFF);
        check("reset_seg",    32'(bus1.Segments), 32'h7F);
        check("reset_led",    32'(bus1.FlagsLED), 32'h0);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk); #1;
        check("first_edge_anodes", 32'(bus1.Anodes), 32'hFE);

        // 0x0100 with flags 0010 and status 3.
        wait_anode(0); check("v0100_an0", 32'(bus1.Segments), 32'(7'b0000001));
        wait_anode(1); check("v0100_an1", 32'(bus1.Segments), 32'(7'b0000001));
        wait_anode(2); check("v0100_an2", 32'(bus1.Segments), 32'(7'b1001111));
        wait_anode(3); check("v0100_an3", 32'(bus1.Segments), 32'(7'b1111111));
        wait_anode(6); check("v0100_an6", 32'(bus1.Segments), 32'(7'b0000110));
        check("v0100_led", 32'(bus1.FlagsLED), 32'b0010);

        // All-zero value: blanking on vs off.
        set_inputs(16'h0000, 4'b0010, 3'd3);
        next_frame();
        check("zero_lzb1_an0", 32'(bus1.Segments), 32'(7'b0000001));
        check("zero_lzb0_an0", 32'(bus0.Segments), 32'(7'b0000001));
        for (int k = 1; k < 4; k++) begin
            wait_anode(k);
            check("zero_lzb1_blank", 32'(bus1.Segments), 32'h7F);
            check("zero_lzb0_shown", 32'(bus0.Segments), 32'(7'b0000001));
        end

        // Mid-frame input change is deferred to the next frame.
        set_inputs(16'h1234, 4'b1000, 3'd1);
        next_frame();
        wait_anode(2);
        set_inputs(16'hABCD, 4'b0101, 3'd7);
        wait_anode(3); check("deferred_an3", 32'(bus1.Segments), 32'(7'b1001111));
        wait_anode(6); check("deferred_an6", 32'(bus1.Segments), 32'(7'b1001111));
        next_frame();  check("abcd_an0", 32'(bus1.Segments), 32'(7'b1000010));
        wait_anode(1); check("abcd_an1", 32'(bus1.Segments), 32'(7'b0110001));
        wait_anode(2); check("abcd_an2", 32'(bus1.Segments), 32'(7'b1100000));
        wait_anode(3); check("abcd_an3", 32'(bus1.Segments), 32'(7'b0001000));
        check("abcd_led", 32'(bus1.FlagsLED), 32'b0101);

        // Dwell and order over one full frame, then the wrap.
        next_frame();
        for (int i = 0; i < 32; i++) begin
            check("dwell_walk", 32'(bus1.Anodes), 32'(8'(~(8'b1 << (i / 4)))));
            @(negedge clk);
        end
        check("dwell_wrap", 32'(bus1.Anodes), 32'hFE);

        // Asynchronous reset during digit 5, then restart with new inputs.
        wait_anode(5);
        #2 resetN = 1'b0;
        #1;
        check("midscan_reset_anodes", 32'(bus1.Anodes),   32'hFF);
        check("midscan_reset_seg",    32'(bus1.Segments), 32'h7F);
        check("midscan_reset_led",    32'(bus1.FlagsLED), 32'h0);
        set_inputs(16'h0042, 4'b1001, 3'd5);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(posedge clk); #1;
        check("restart_anodes", 32'(bus1.Anodes), 32'hFE);
        @(posedge clk); #1;
        check("restart_an0_seg", 32'(bus1.Segments), 32'(7'b0010010));
        check("restart_led",     32'(bus1.FlagsLED), 32'b1001);
        wait_anode(1); check("restart_an1", 32'(bus1.Segments), 32'(7'b1001100));
        wait_anode(2); check("restart_an2", 32'(bus1.Segments), 32'h7F);
        wait_anode(6); check("restart_an6", 32'(bus1.Segments), 32'(7'b0100100));
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/rpn_display_driver.md
RPN_DISPLAY_DRIVER -- requirements
Module: rpn_display_driver

Interface
REQ-001 Parameter COUNT_MAX, default 50000, clock cycles each digit stays active (legal range 2..65535).
REQ-002 Parameter LZB, default 1, enables leading-zero blanking of the ToDisplay hex field when 1.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 resetN  input  1  asynchronous, active-low reset.
REQ-005 ToDisplay  input  16  calculator result/operand value, shown as 4 hex digits.
REQ-006 Flags  input  4  calculator flags {N,Z,C,V}.
REQ-007 Status  input  3  calculator sequencer state, shown as one hex digit.
REQ-008 Anodes  output  8  digit enables, active-low, bit k selects digit k (digit 0 rightmost).
REQ-009 Segments  output  7  segment drive, active-low, bit6..bit0 = {CA,CB,CC,CD,CE,CF,CG}.
REQ-010 FlagsLED  output  4  {N,Z,C,V} to LEDs, active-high.

Function
REQ-011 Prescaler counts 0..COUNT_MAX-1 and wraps to 0; terminal count (TC) = prescaler equal to COUNT_MAX-1.
REQ-012 Digit index (3 bit) advances by 1 on each TC, wrapping 7->0; no other event changes it.
REQ-013 Shadow registers hold ToDisplay, Flags and Status; the display reads only shadows, never the live inputs.
REQ-014 Shadows load from inputs on TC with index 7 (frame wrap); input changes mid-frame are not displayed until the next frame.
REQ-015 A load_pending flag, set by reset, also loads shadows on the first clock edge after reset release, then clears.
REQ-016 Anodes, Segments and FlagsLED are registered; they reflect the current index and shadows with 1-cycle latency.
REQ-017 Each digit index holds its anode active for exactly COUNT_MAX consecutive cycles.
REQ-018 Exactly one Anodes bit is low at any time after the first edge following reset release.
REQ-019 Digit map: idx 0..3 = shadow ToDisplay nibbles [3:0],[7:4],[11:8],[15:12]; idx 6 = {1'b0,Status}; idx 4,5,7 = blank.
REQ-020 Hex encoding (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - blank=1111111
REQ-021 A blank digit still drives its anode low with Segments 1111111.
REQ-022 With LZB=1, digit k (k=3..1) of the ToDisplay field is blanked when it and all higher ToDisplay nibbles are zero; digit 0 is never blanked.
REQ-023 With LZB=0, all four ToDisplay digits always show.
REQ-024 FlagsLED equals shadow Flags, updated with the shadow load plus one cycle of register latency.

Reset
REQ-025 While resetN=0, independent of clk: prescaler=0, index=0, shadows=0, load_pending=1, Anodes=8'hFF, Segments=7'h7F, FlagsLED=4'h0.
REQ-026 Reset asserted mid-scan forces these values immediately; after release, scanning restarts at index 0 with a full COUNT_MAX dwell.

Verification (COUNT_MAX=4)
REQ-027 Reset: resetN=0 -> Anodes=FF, Segments=7F, FlagsLED=0; after release and one edge -> Anodes=FE.
REQ-028 ToDisplay=16'h0100, Flags=4'b0010, Status=3 held from reset -> one frame shows:
  - AN0 "0", AN1 "0", AN2 "1", AN3 blank, AN6 "3"
  - FlagsLED=0010
REQ-029 ToDisplay=16'h0000, LZB=1 -> only AN0 shows "0"; AN1-3 blank. With LZB=0, all four digits show "0".
REQ-030 ToDisplay changed 16'h1234->16'hABCD during idx 2 -> rest of frame shows 1234; next frame shows "d","C","b","A".
REQ-031 Dwell/order: 32 cycles -> anode low bit walks 0..7, each exactly 4 cycles, and wraps back to bit 0.
REQ-032 resetN pulsed low during idx 5 -> immediate FF/7F/0; after release, scanning restarts at AN0 with the current inputs loaded.
